// File: rtl/spread_window_stats.sv
// Windowed bid/ask spread statistics: last spread, sliding sum/average, FSM-rescanned min/max.
// Optional SPREAD_CROSS_EN macro adds a registered crossed-book flag on the last accepted sample.
module spread_window_stats #(
    parameter int unsigned PRICE_W    = 8,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  match_signal,
    input  logic                  enable_count,
    input  logic [PRICE_W-1:0]    buy_price,
    input  logic [PRICE_W-1:0]    sell_price,
    output logic [PRICE_W-1:0]    spread_now,
    output logic                  spread_valid,
    output logic                  sample_pulse,
    output logic [LOG2_DEPTH:0]   fill_count,
    output logic [PRICE_W-1:0]    spread_avg,
    output logic                  avg_valid,
    output logic [PRICE_W-1:0]    spread_min,
    output logic [PRICE_W-1:0]    spread_max,
    output logic                  stats_valid,
    output logic [15:0]           reject_count,
    output logic                  crossed
);
    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned SUM_W = PRICE_W + LOG2_DEPTH;
    localparam int unsigned CNT_W = LOG2_DEPTH + 1;

    typedef enum logic {StIdle, StScan} state_e;

    logic [PRICE_W-1:0]    buf_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wptr_q;
    logic [CNT_W-1:0]      fill_q;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [PRICE_W-1:0]    spread_q, spread_calc;
    logic                  pulse_q;
    logic [15:0]           reject_q;
    state_e                state_q, state_d;
    logic [LOG2_DEPTH-1:0] idx_q, idx_d;
    logic [PRICE_W-1:0]    run_min_q, run_min_d, run_max_q, run_max_d;
    logic [PRICE_W-1:0]    min_q, min_d, max_q, max_d;
    logic [PRICE_W-1:0]    scan_val, scan_min, scan_max;
    logic                  book_ok, sample_req, accept, reject, full;

    assign book_ok     = (buy_price != '0) && (sell_price != '1);
    assign sample_req  = match_signal & enable_count & ~clear & ~reset;
    assign accept      = sample_req & book_ok;
    assign reject      = sample_req & ~book_ok;
    assign spread_calc = (buy_price >= sell_price) ? (buy_price - sell_price)
                                                   : (sell_price - buy_price);
    assign full        = (fill_q == CNT_W'(DEPTH));
    // Oldest entry sits at wptr once the window is full, so it is the one evicted.
    assign sum_d       = sum_q + SUM_W'(spread_calc) - (full ? SUM_W'(buf_q[wptr_q]) : '0);

    assign scan_val = buf_q[idx_q];
    assign scan_min = (scan_val < run_min_q) ? scan_val : run_min_q;
    assign scan_max = (scan_val > run_max_q) ? scan_val : run_max_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
        if (accept) begin
            state_d   = StScan;
            idx_d     = '0;
            run_min_d = '1;
            run_max_d = '0;
        end else begin
            case (state_q)
                StScan: begin
                    run_min_d = scan_min;
                    run_max_d = scan_max;
                    idx_d     = idx_q + LOG2_DEPTH'(1);
                    if (CNT_W'(idx_q) == fill_q - CNT_W'(1)) begin
                        state_d = StIdle;
                        min_d   = scan_min;
                        max_d   = scan_max;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
            wptr_q    <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            spread_q  <= '0;
            pulse_q   <= 1'b0;
            reject_q  <= '0;
            state_q   <= StIdle;
            idx_q     <= '0;
            run_min_q <= '0;
            run_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            pulse_q <= accept;
            if (accept) begin
                spread_q      <= spread_calc;
                buf_q[wptr_q] <= spread_calc;
                wptr_q        <= wptr_q + LOG2_DEPTH'(1);
                sum_q         <= sum_d;
                if (!full) fill_q <= fill_q + CNT_W'(1);
            end
            if (reject && reject_q != 16'hFFFF) reject_q <= reject_q + 16'd1;
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

`ifdef SPREAD_CROSS_EN
    logic crossed_q;
    always_ff @(posedge clk) begin
        if (reset || clear) crossed_q <= 1'b0;
        else if (accept)    crossed_q <= (buy_price > sell_price);
    end
    assign crossed = crossed_q;
`else
    assign crossed = 1'b0;
`endif

    assign spread_now   = spread_q;
    assign spread_valid = (fill_q != '0);
    assign sample_pulse = pulse_q;
    assign fill_count   = fill_q;
    assign avg_valid    = full;
    assign spread_avg   = full ? PRICE_W'(sum_q >> LOG2_DEPTH) : '0;
    assign spread_min   = min_q;
    assign spread_max   = max_q;
    assign stats_valid  = (state_q == StIdle) && (fill_q != '0);
    assign reject_count = reject_q;
endmodule

// File: tb/tb_spread_window_stats.sv
// Randomized and directed bench for spread_window_stats against a queue-based window model.
module tb_spread_window_stats;
    logic        clk = 1'b0;
    logic        reset, clear, match_signal, enable_count;
    logic [7:0]  buy_price, sell_price;
    logic [7:0]  spread_now, spread_avg, spread_min, spread_max;
    logic        spread_valid, sample_pulse, avg_valid, stats_valid, crossed;
    logic [3:0]  fill_count;
    logic [15:0] reject_count;

    spread_window_stats #(.PRICE_W(8), .LOG2_DEPTH(3)) dut (
        .clk(clk), .reset(reset), .clear(clear), .match_signal(match_signal),
        .enable_count(enable_count), .buy_price(buy_price), .sell_price(sell_price),
        .spread_now(spread_now), .spread_valid(spread_valid), .sample_pulse(sample_pulse),
        .fill_count(fill_count), .spread_avg(spread_avg), .avg_valid(avg_valid),
        .spread_min(spread_min), .spread_max(spread_max), .stats_valid(stats_valid),
        .reject_count(reject_count), .crossed(crossed)
    );

    always #5 clk = ~clk;

    localparam int D = 8;
    int q[$];
    int m_spread, m_pulse, m_reject, m_crossed, m_scan, m_min, m_max;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int win_sum();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    // Scan length equals the window occupancy at the accept; min/max update when it ends.
    task automatic model(input bit r, c, m, e, input int b, s);
        if (r || c) begin
            q.delete();
            m_spread = 0; m_pulse = 0; m_reject = 0; m_crossed = 0;
            m_scan = 0; m_min = 0; m_max = 0;
        end else begin
            bit ok = (b != 0) && (s != 255);
            m_pulse = m && e && ok;
            if (m && e && !ok && m_reject < 65535) m_reject++;
            if (m && e && ok) begin
                m_spread = (b > s) ? b - s : s - b;
                q.push_back(m_spread);
                if (q.size() > D) void'(q.pop_front());
`ifdef SPREAD_CROSS_EN
                m_crossed = (b > s) ? 1 : 0;
`endif
                m_scan = q.size();
            end else if (m_scan > 0) begin
                m_scan--;
                if (m_scan == 0) begin
                    m_min = 255; m_max = 0;
                    foreach (q[i]) begin
                        if (q[i] < m_min) m_min = q[i];
                        if (q[i] > m_max) m_max = q[i];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("spread_now", 32'(spread_now), m_spread);
        chk("spread_valid", 32'(spread_valid), (q.size() > 0) ? 1 : 0);
        chk("sample_pulse", 32'(sample_pulse), m_pulse);
        chk("fill_count", 32'(fill_count), q.size());
        chk("spread_avg", 32'(spread_avg), (q.size() == D) ? (win_sum() >> 3) : 0);
        chk("avg_valid", 32'(avg_valid), (q.size() == D) ? 1 : 0);
        chk("stats_valid", 32'(stats_valid), (m_scan == 0 && q.size() > 0) ? 1 : 0);
        chk("spread_min", 32'(spread_min), m_min);
        chk("spread_max", 32'(spread_max), m_max);
        chk("reject_count", 32'(reject_count), m_reject);
        chk("crossed", 32'(crossed), m_crossed);
    endtask

    task automatic step(input bit r, c, m, e, input int b, s);
        reset = r; clear = c; match_signal = m; enable_count = e;
        buy_price = b[7:0]; sell_price = s[7:0];
        @(posedge clk);
        model(r, c, m, e, b, s);
        #1 check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int prev;
        reset = 1; clear = 0; match_signal = 0; enable_count = 0;
        buy_price = 0; sell_price = 0;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // reset during an active scan
        step(0, 0, 1, 1, 60, 50);
        step(0, 0, 1, 1, 60, 53);
        step(0, 0, 1, 1, 60, 57);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t1_fill", 32'(fill_count), 0);
        chk("t1_stats_valid", 32'(stats_valid), 0);

        // spreads 1..8 fill the window
        for (int k = 1; k <= 8; k++) step(0, 0, 1, 1, 100 + k, 100);
        idle(8);
        chk("t2_avg", 32'(spread_avg), 4);
        chk("t2_min", 32'(spread_min), 1);
        chk("t2_max", 32'(spread_max), 8);
        chk("t2_avg_valid", 32'(avg_valid), 1);

        // ninth sample evicts the oldest
        step(0, 0, 1, 1, 80, 100);
        idle(8);
        chk("t3_avg", 32'(spread_avg), 6);
        chk("t3_min", 32'(spread_min), 2);
        chk("t3_max", 32'(spread_max), 20);

        // empty-book rejects
        prev = m_reject;
        step(0, 0, 1, 1, 0, 40);
        chk("t4_rej_bid", 32'(reject_count), prev + 1);
        step(0, 0, 1, 1, 40, 255);
        chk("t4_rej_ask", 32'(reject_count), prev + 2);
        chk("t4_spread", 32'(spread_now), 20);
        step(0, 0, 1, 0, 70, 60);

        // crossed then normal book
        step(0, 0, 1, 1, 50, 40);
        chk("t5_spread_a", 32'(spread_now), 10);
        step(0, 0, 1, 1, 40, 50);
        chk("t5_spread_b", 32'(spread_now), 10);
        idle(9);

        // accept on the second scan cycle restarts the scan
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 30, 25);
        step(0, 0, 1, 1, 30, 18);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 30, 29);
        chk("t6_stats_valid", 32'(stats_valid), 0);
        idle(3);
        chk("t6_min", 32'(spread_min), 1);
        chk("t6_max", 32'(spread_max), 12);

        for (int i = 0; i < 600; i++) begin
            int b, s;
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            s = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 254));
            step(($urandom_range(0, 249) == 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0), b, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
